// File: rtl/csr_trap_unit.sv
// Machine-mode CSR file and trap controller. It commits one instruction per cycle
// and registers a single redirect (pc + flush) for each trap, mret or CSR write.
module csr_trap_unit #(
    parameter int unsigned NUM_PLAT_IRQ = 4,
    parameter bit          VECTORED_EN  = 1'b1,
    parameter logic [63:0] RESET_PC_VEC = 64'h8000_0000
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    stall,
    input  logic                    cm_valid,
    input  logic [63:0]             cm_pc,
    input  logic                    cm_exc,
    input  logic [3:0]              cm_exc_code,
    input  logic                    cm_mret,
    input  logic [1:0]              cm_csr_op,
    input  logic [11:0]             cm_csr_addr,
    input  logic [63:0]             cm_csr_src,
    input  logic [11:0]             ra,
    output logic [63:0]             rd,
    input  logic                    irq_mti,
    input  logic                    irq_msi,
    input  logic                    irq_mei,
    input  logic [NUM_PLAT_IRQ-1:0] irq_plat,
    output logic                    redirect_valid,
    output logic [63:0]             redirect_pc,
    output logic [1:0]              mode
);

    typedef enum logic [1:0] {CSR_NONE, CSR_W, CSR_S, CSR_C} csr_op_e;

    localparam logic [11:0] A_MSTATUS  = 12'h300;
    localparam logic [11:0] A_MIE      = 12'h304;
    localparam logic [11:0] A_MTVEC    = 12'h305;
    localparam logic [11:0] A_MSCRATCH = 12'h340;
    localparam logic [11:0] A_MEPC     = 12'h341;
    localparam logic [11:0] A_MCAUSE   = 12'h342;
    localparam logic [11:0] A_MTVAL    = 12'h343;
    localparam logic [11:0] A_MIP      = 12'h344;
    localparam logic [11:0] A_MCYCLE   = 12'hB00;
    localparam logic [11:0] A_MINSTRET = 12'hB02;

    localparam logic [63:0] PLAT_MASK    = ((64'd1 << NUM_PLAT_IRQ) - 64'd1) << 16;
    localparam logic [63:0] MIE_MASK     = PLAT_MASK | 64'h888;
    localparam logic [63:0] MSTATUS_MASK = 64'h1888;

    logic [63:0] r_mstatus, r_mie, r_mip, r_mtvec, r_mepc, r_mcause;
    logic [63:0] r_mtval, r_mscratch, r_mcycle, r_minstret;
    logic [1:0]  r_mode;
    logic [NUM_PLAT_IRQ-1:0] r_plat_d;
    logic        r_redirect_valid;
    logic [63:0] r_redirect_pc;

    csr_op_e     w_op;
    logic [63:0] w_csr [10];
    logic [3:0]  w_ra_idx, w_wr_idx;
    logic [63:0] w_old, w_wdata, w_pend, w_base, w_target, w_mip_next;
    logic [4:0]  w_irq_code, w_cause_code;
    logic [NUM_PLAT_IRQ-1:0] w_plat_keep;
    logic        w_commit, w_irq, w_exc, w_trap, w_mret, w_csr_wr, w_retire, w_action;

    function automatic logic [3:0] csr_idx(input logic [11:0] a);
        case (a)
            A_MSTATUS:  return 4'd0;
            A_MIE:      return 4'd1;
            A_MIP:      return 4'd2;
            A_MTVEC:    return 4'd3;
            A_MEPC:     return 4'd4;
            A_MCAUSE:   return 4'd5;
            A_MTVAL:    return 4'd6;
            A_MSCRATCH: return 4'd7;
            A_MCYCLE:   return 4'd8;
            A_MINSTRET: return 4'd9;
            default:    return 4'd15;
        endcase
    endfunction

    always_comb begin
        w_csr[0] = r_mstatus;
        w_csr[1] = r_mie;
        w_csr[2] = r_mip;
        w_csr[3] = r_mtvec;
        w_csr[4] = r_mepc;
        w_csr[5] = r_mcause;
        w_csr[6] = r_mtval;
        w_csr[7] = r_mscratch;
        w_csr[8] = r_mcycle;
        w_csr[9] = r_minstret;
    end

    always_comb begin
        w_ra_idx = csr_idx(ra);
        w_wr_idx = csr_idx(cm_csr_addr);
        rd       = (w_ra_idx < 4'd10) ? w_csr[w_ra_idx] : '0;
        w_old    = (w_wr_idx < 4'd10) ? w_csr[w_wr_idx] : '0;
    end

    assign w_op   = csr_op_e'(cm_csr_op);
    assign w_pend = r_mip & r_mie;

    // Later assignments win: MEI > MSI > MTI > lowest-index platform line.
    always_comb begin
        w_irq_code = '0;
        for (int unsigned i = 0; i < NUM_PLAT_IRQ; i++) begin
            if (w_pend[16 + NUM_PLAT_IRQ - 1 - i])
                w_irq_code = 5'(16 + NUM_PLAT_IRQ - 1 - i);
        end
        if (w_pend[7])  w_irq_code = 5'd7;
        if (w_pend[3])  w_irq_code = 5'd3;
        if (w_pend[11]) w_irq_code = 5'd11;
    end

    assign w_commit = cm_valid & ~stall;
    assign w_irq    = w_commit & r_mstatus[3] & (|w_pend);
    assign w_exc    = w_commit & cm_exc;
    assign w_trap   = w_exc | w_irq;
    assign w_retire = w_commit & ~cm_exc & ~w_irq;
    assign w_mret   = w_retire & cm_mret;
    assign w_csr_wr = w_retire & ~cm_mret & (w_op != CSR_NONE);
    assign w_action = w_trap | w_mret | w_csr_wr;

    always_comb begin
        case (w_op)
            CSR_S:   w_wdata = w_old | cm_csr_src;
            CSR_C:   w_wdata = w_old & ~cm_csr_src;
            default: w_wdata = cm_csr_src;
        endcase
    end

    always_comb begin
        w_cause_code = w_exc ? {1'b0, cm_exc_code} : w_irq_code;
        w_base       = {r_mtvec[63:2], 2'b00};
        if (w_trap) begin
            if (VECTORED_EN && (r_mtvec[1:0] == 2'b01) && !w_exc)
                w_target = w_base + {57'd0, w_cause_code, 2'b00};
            else
                w_target = w_base;
        end else if (w_mret) begin
            w_target = r_mepc;
        end else begin
            w_target = cm_pc + 64'd4;
        end
    end

    // Platform bits can only be cleared by software; a same-cycle edge re-sets them.
    always_comb begin
        w_mip_next     = '0;
        w_mip_next[3]  = irq_msi;
        w_mip_next[7]  = irq_mti;
        w_mip_next[11] = irq_mei;
        w_plat_keep    = r_mip[16 +: NUM_PLAT_IRQ];
        if (w_csr_wr && cm_csr_addr == A_MIP)
            w_plat_keep = w_plat_keep & w_wdata[16 +: NUM_PLAT_IRQ];
        w_mip_next[16 +: NUM_PLAT_IRQ] = w_plat_keep | (irq_plat & ~r_plat_d);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_mstatus        <= '0;
            r_mie            <= '0;
            r_mip            <= '0;
            r_mtvec          <= RESET_PC_VEC;
            r_mepc           <= RESET_PC_VEC;
            r_mcause         <= '0;
            r_mtval          <= '0;
            r_mscratch       <= '0;
            r_mcycle         <= '0;
            r_minstret       <= '0;
            r_mode           <= 2'b11;
            r_plat_d         <= '0;
            r_redirect_valid <= 1'b0;
            r_redirect_pc    <= '0;
        end else begin
            r_mip            <= w_mip_next;
            r_plat_d         <= irq_plat;
            r_redirect_valid <= w_action;
            if (w_action)
                r_redirect_pc <= w_target;
            if (w_csr_wr && cm_csr_addr == A_MCYCLE)
                r_mcycle <= w_wdata;
            else
                r_mcycle <= r_mcycle + 64'd1;
            if (w_csr_wr && cm_csr_addr == A_MINSTRET)
                r_minstret <= w_wdata;
            else if (w_retire)
                r_minstret <= r_minstret + 64'd1;

            if (w_trap) begin
                r_mepc             <= cm_pc;
                r_mtval            <= '0;
                r_mcause           <= {~w_exc, 58'd0, w_cause_code};
                r_mstatus[7]       <= r_mstatus[3];
                r_mstatus[3]       <= 1'b0;
                r_mstatus[12:11]   <= r_mode;
                r_mode             <= 2'b11;
            end else if (w_mret) begin
                r_mstatus[3]       <= r_mstatus[7];
                r_mstatus[7]       <= 1'b1;
                r_mstatus[12:11]   <= 2'b00;
                r_mode             <= r_mstatus[12:11];
            end else if (w_csr_wr) begin
                case (cm_csr_addr)
                    A_MSTATUS:  r_mstatus  <= w_wdata & MSTATUS_MASK;
                    A_MIE:      r_mie      <= w_wdata & MIE_MASK;
                    A_MTVEC:    r_mtvec    <= w_wdata;
                    A_MEPC:     r_mepc     <= w_wdata;
                    A_MCAUSE:   r_mcause   <= w_wdata;
                    A_MTVAL:    r_mtval    <= w_wdata;
                    A_MSCRATCH: r_mscratch <= w_wdata;
                    default:    ;
                endcase
            end
        end
    end

    assign redirect_valid = r_redirect_valid;
    assign redirect_pc    = r_redirect_pc;
    assign mode           = r_mode;

endmodule

// File: tb/tb_csr_trap_unit.sv
// Self-checking bench for csr_trap_unit: directed scenarios plus random commits,
// scored against a field-level behavioural model of the machine-mode CSRs.
`timescale 1ns/1ps
module tb_csr_trap_unit;

    localparam int unsigned NP = 4;

    logic          clk = 1'b0;
    logic          reset, stall, cm_valid, cm_exc, cm_mret;
    logic [63:0]   cm_pc, cm_csr_src, rd, redirect_pc;
    logic [3:0]    cm_exc_code;
    logic [1:0]    cm_csr_op, mode;
    logic [11:0]   cm_csr_addr, ra;
    logic          irq_mti, irq_msi, irq_mei, redirect_valid;
    logic [NP-1:0] irq_plat;

    always #50 clk = ~clk;

    csr_trap_unit #(.NUM_PLAT_IRQ(NP), .VECTORED_EN(1'b1), .RESET_PC_VEC(64'h8000_0000)) dut (
        .clk(clk), .reset(reset), .stall(stall), .cm_valid(cm_valid), .cm_pc(cm_pc),
        .cm_exc(cm_exc), .cm_exc_code(cm_exc_code), .cm_mret(cm_mret), .cm_csr_op(cm_csr_op),
        .cm_csr_addr(cm_csr_addr), .cm_csr_src(cm_csr_src), .ra(ra), .rd(rd),
        .irq_mti(irq_mti), .irq_msi(irq_msi), .irq_mei(irq_mei), .irq_plat(irq_plat),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .mode(mode)
    );

    typedef struct { bit act; logic [63:0] pc; } exp_t;
    exp_t q[$];
    int tests = 0;
    int fails = 0;

    logic [11:0] addrs [11] = '{12'h300, 12'h304, 12'h305, 12'h340, 12'h341, 12'h342,
                                12'h343, 12'h344, 12'hB00, 12'hB02, 12'h7C0};
    logic [3:0]  codes [5]  = '{4'd0, 4'd2, 4'd4, 4'd6, 4'd8};

    // Reference state kept as individual architectural fields.
    bit          m_mie_b, m_mpie, m_msi, m_mti, m_mei;
    logic [1:0]  m_mpp, m_mode;
    logic [63:0] m_mie, m_mtvec, m_mepc, m_mcause, m_mtval, m_mscratch, m_mcycle, m_minstret;
    bit          m_plat [NP];
    bit          m_prev [NP];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_mie_b = 0; m_mpie = 0; m_msi = 0; m_mti = 0; m_mei = 0;
        m_mpp = 0; m_mode = 2'd3; m_mie = 0;
        m_mtvec = 64'h8000_0000; m_mepc = 64'h8000_0000;
        m_mcause = 0; m_mtval = 0; m_mscratch = 0; m_mcycle = 0; m_minstret = 0;
        for (int i = 0; i < NP; i++) begin m_plat[i] = 0; m_prev[i] = 0; end
    endtask

    function automatic logic [63:0] model_read(input logic [11:0] a);
        logic [63:0] v;
        v = 0;
        case (a)
            12'h300: begin v[3] = m_mie_b; v[7] = m_mpie; v[12:11] = m_mpp; end
            12'h304: v = m_mie;
            12'h305: v = m_mtvec;
            12'h340: v = m_mscratch;
            12'h341: v = m_mepc;
            12'h342: v = m_mcause;
            12'h343: v = m_mtval;
            12'h344: begin
                v[3] = m_msi; v[7] = m_mti; v[11] = m_mei;
                for (int i = 0; i < NP; i++) v[16+i] = m_plat[i];
            end
            12'hB00: v = m_mcycle;
            12'hB02: v = m_minstret;
            default: v = 0;
        endcase
        return v;
    endfunction

    task automatic model_step();
        bit commit, irq, wr, act, is_irq;
        int code;
        logic [63:0] old, wv, tgt, mask;
        logic [11:0] wa;
        commit = cm_valid && !stall;
        code = -1; wr = 0; act = 0; tgt = 0; wv = 0; wa = cm_csr_addr; is_irq = 0;
        if (m_mei && m_mie[11])      code = 11;
        else if (m_msi && m_mie[3])  code = 3;
        else if (m_mti && m_mie[7])  code = 7;
        else for (int i = 0; i < NP; i++)
            if (code < 0 && m_plat[i] && m_mie[16+i]) code = 16 + i;
        irq = commit && m_mie_b && (code >= 0);
        if ((commit && cm_exc) || irq) begin
            is_irq = !cm_exc;
            if (!is_irq) code = int'(cm_exc_code);
            m_mepc = cm_pc; m_mtval = 0;
            m_mcause = 64'(code); m_mcause[63] = is_irq;
            m_mpie = m_mie_b; m_mie_b = 0; m_mpp = m_mode; m_mode = 2'd3;
            tgt = m_mtvec & ~64'd3;
            if (is_irq && m_mtvec[1:0] == 2'd1) tgt = tgt + 64'(4 * code);
            act = 1;
        end else if (commit && cm_mret) begin
            m_mie_b = m_mpie; m_mpie = 1; m_mode = m_mpp; m_mpp = 0;
            tgt = m_mepc; act = 1;
        end else if (commit && cm_csr_op != 2'd0) begin
            old = model_read(wa);
            case (cm_csr_op)
                2'd1:    wv = cm_csr_src;
                2'd2:    wv = old | cm_csr_src;
                default: wv = old & ~cm_csr_src;
            endcase
            wr = 1; act = 1; tgt = cm_pc + 64'd4;
        end
        if (wr) begin
            case (wa)
                12'h300: begin m_mie_b = wv[3]; m_mpie = wv[7]; m_mpp = wv[12:11]; end
                12'h304: begin
                    mask = 64'h888;
                    for (int i = 0; i < NP; i++) mask[16+i] = 1'b1;
                    m_mie = wv & mask;
                end
                12'h305: m_mtvec = wv;
                12'h340: m_mscratch = wv;
                12'h341: m_mepc = wv;
                12'h342: m_mcause = wv;
                12'h343: m_mtval = wv;
                12'h344: for (int i = 0; i < NP; i++) m_plat[i] = m_plat[i] && wv[16+i];
                default: ;
            endcase
        end
        if (wr && wa == 12'hB00) m_mcycle = wv; else m_mcycle = m_mcycle + 64'd1;
        if (wr && wa == 12'hB02) m_minstret = wv;
        else if (commit && !cm_exc && !irq) m_minstret = m_minstret + 64'd1;
        m_msi = irq_msi; m_mti = irq_mti; m_mei = irq_mei;
        for (int i = 0; i < NP; i++) begin
            if (irq_plat[i] && !m_prev[i]) m_plat[i] = 1;
            m_prev[i] = irq_plat[i];
        end
        q.push_back('{act, tgt});
    endtask

    task automatic idle();
        stall = 0; cm_valid = 0; cm_pc = 0; cm_exc = 0; cm_exc_code = 0; cm_mret = 0;
        cm_csr_op = 0; cm_csr_addr = 0; cm_csr_src = 0;
    endtask

    task automatic tick();
        model_step();
        @(negedge clk);
        ra = addrs[$urandom_range(0, 10)];
        #1;
        chk("rd_rand", rd, model_read(ra));
        chk("mode", {62'd0, mode}, {62'd0, m_mode});
    endtask

    task automatic rdchk(input string name, input logic [11:0] a, input logic [63:0] exp);
        ra = a;
        #1;
        chk(name, rd, exp);
    endtask

    task automatic csr(input logic [1:0] op, input logic [11:0] a, input logic [63:0] src,
                       input logic [63:0] pc);
        idle();
        cm_valid = 1; cm_csr_op = op; cm_csr_addr = a; cm_csr_src = src; cm_pc = pc;
        tick();
        idle();
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() == 0) begin
                chk("redirect_idle", {63'd0, redirect_valid}, 64'd0);
            end else begin
                e = q.pop_front();
                chk("redirect_valid", {63'd0, redirect_valid}, {63'd0, e.act});
                if (e.act) chk("redirect_pc", redirect_pc, e.pc);
            end
        end
    end

    initial begin : watchdog
        #10_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : stim
        reset = 1; idle(); ra = 0;
        irq_mti = 0; irq_msi = 0; irq_mei = 0; irq_plat = 0;
        repeat (3) @(negedge clk);
        reset = 0;
        model_reset();
        chk("rst_redirect_valid", {63'd0, redirect_valid}, 64'd0);
        rdchk("rst_mtvec", 12'h305, 64'h8000_0000);
        rdchk("rst_mepc", 12'h341, 64'h8000_0000);
        chk("rst_mode", {62'd0, mode}, 64'd3);

        csr(2'd1, 12'h305, 64'h1001, 64'h100);
        csr(2'd1, 12'h304, 64'h800, 64'h104);
        csr(2'd1, 12'h300, 64'h8, 64'h108);
        irq_mei = 1;
        tick();
        cm_valid = 1; cm_pc = 64'h8000_0100;
        tick();
        idle();
        chk("mei_redirect_valid", {63'd0, redirect_valid}, 64'd1);
        chk("mei_redirect_pc", redirect_pc, 64'h102C);
        rdchk("mei_mcause", 12'h342, 64'h8000_0000_0000_000B);
        rdchk("mei_mepc", 12'h341, 64'h8000_0100);
        ra = 12'h300; #1;
        chk("mei_MIE", {63'd0, rd[3]}, 64'd0);
        chk("mei_MPIE", {63'd0, rd[7]}, 64'd1);
        irq_mei = 0;

        irq_plat = 4'b0100;
        tick();
        irq_plat = 0;
        tick();
        tick();
        ra = 12'h344; #1;
        chk("plat_sticky", {63'd0, rd[18]}, 64'd1);
        csr(2'd3, 12'h344, 64'd1 << 18, 64'h300);
        ra = 12'h344; #1;
        chk("plat_clear", {63'd0, rd[18]}, 64'd0);
        irq_plat = 4'b0100;
        csr(2'd3, 12'h344, 64'd1 << 18, 64'h304);
        irq_plat = 0;
        ra = 12'h344; #1;
        chk("plat_set_wins", {63'd0, rd[18]}, 64'd1);

        cm_valid = 1; cm_exc = 1; cm_exc_code = 4'd8; cm_pc = 64'h200;
        cm_csr_op = 2'd1; cm_csr_addr = 12'h340; cm_csr_src = 64'd5;
        tick();
        idle();
        chk("ecall_redirect_pc", redirect_pc, 64'h1000);
        rdchk("ecall_mcause", 12'h342, 64'd8);
        rdchk("ecall_mscratch", 12'h340, 64'd0);

        csr(2'd1, 12'h300, 64'h80, 64'h204);
        cm_valid = 1; cm_mret = 1; stall = 1; cm_pc = 64'h208;
        tick();
        chk("stall_no_redirect", {63'd0, redirect_valid}, 64'd0);
        chk("stall_mode", {62'd0, mode}, 64'd3);
        rdchk("stall_mstatus", 12'h300, 64'h80);
        stall = 0;
        tick();
        idle();
        chk("mret_redirect_pc", redirect_pc, 64'h200);
        chk("mret_mode", {62'd0, mode}, 64'd0);
        ra = 12'h300; #1;
        chk("mret_MIE", {63'd0, rd[3]}, 64'd1);

        csr(2'd1, 12'hB00, '1, 64'h400);
        rdchk("mcycle_written", 12'hB00, 64'hFFFF_FFFF_FFFF_FFFF);
        tick();
        rdchk("mcycle_wrap", 12'hB00, 64'd0);
        csr(2'd1, 12'hB02, 64'd0, 64'h404);
        rdchk("minstret_zero", 12'hB02, 64'd0);
        for (int i = 0; i < 3; i++) begin
            cm_valid = 1; cm_pc = 64'h408 + 64'(4 * i);
            tick();
        end
        idle();
        rdchk("minstret_three", 12'hB02, 64'd3);

        cm_valid = 1; cm_exc = 1; cm_pc = 64'h500;
        reset = 1;
        model_reset();
        q.push_back('{1'b0, 64'd0});
        @(negedge clk);
        reset = 0;
        idle();
        chk("rst_mid_valid", {63'd0, redirect_valid}, 64'd0);
        rdchk("rst_mid_mtvec", 12'h305, 64'h8000_0000);

        for (int n = 0; n < 3000; n++) begin
            stall       = ($urandom_range(0, 9) == 0);
            cm_valid    = ($urandom_range(0, 9) < 7);
            cm_pc       = {$urandom, $urandom};
            cm_exc      = ($urandom_range(0, 9) == 0);
            cm_exc_code = codes[$urandom_range(0, 4)];
            cm_mret     = ($urandom_range(0, 11) == 0);
            cm_csr_op   = 2'($urandom_range(0, 3));
            cm_csr_addr = addrs[$urandom_range(0, 10)];
            cm_csr_src  = $urandom_range(0, 1) ? {$urandom, $urandom}
                        : (64'($urandom_range(0, 15)) << (4 * $urandom_range(0, 5)));
            if ($urandom_range(0, 7) == 0) irq_mei = ~irq_mei;
            if ($urandom_range(0, 7) == 0) irq_msi = ~irq_msi;
            if ($urandom_range(0, 7) == 0) irq_mti = ~irq_mti;
            if ($urandom_range(0, 5) == 0) irq_plat[$urandom_range(0, NP - 1)] ^= 1'b1;
            tick();
        end
        idle();
        for (int w = 0; w < 5 && q.size() != 0; w++) @(negedge clk);
        chk("scoreboard_drained", 64'(q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/csr_trap_unit.md
Name: csr_trap_unit

Overview:
- Next-generation machine-mode CSR file and trap controller; sits beside the memory stage and consumes the committing instruction each cycle.
- Adds over the previous CSR block: a parametrised count of platform interrupt lines, latched as sticky pending bits (mip[16+i]); fixed interrupt priority; vectored mtvec mode; minstret; corrected CSRC semantics.
- Produces one registered redirect (pc + flush) per trap, mret or CSR write.

Parameters:
- NUM_PLAT_IRQ, 4, platform interrupt lines mapped to mip/mie bits 16..16+NUM_PLAT_IRQ-1 (1..16).
- VECTORED_EN, 1, 1 = honour mtvec.MODE==1; 0 = treat MODE as direct.
- RESET_PC_VEC, 64'h8000_0000, reset value of mtvec and mepc.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous active-high reset
- stall  in  1  pipeline stalled; no commit-side action this cycle
- cm_valid  in  1  committing instruction valid
- cm_pc  in  64  pc of committing instruction
- cm_exc  in  1  instruction raised a synchronous exception
- cm_exc_code  in  4  exception cause code (0, 2, 4, 6, or 8 = ecall)
- cm_mret  in  1  instruction is mret
- cm_csr_op  in  2  0 none, 1 CSRW, 2 CSRS, 3 CSRC
- cm_csr_addr  in  12  CSR destination
- cm_csr_src  in  64  rs1 value or zero-extended uimm
- ra  in  12  read address
- rd  out  64  read data (combinational, pre-commit value)
- irq_mti, irq_msi, irq_mei  in  1 each  level-sensitive core interrupts
- irq_plat  in  NUM_PLAT_IRQ  level inputs; rising edges latched
- redirect_valid  out  1  registered; pulse one cycle
- redirect_pc  out  64  registered target
- mode  out  2  current privilege (3 = M, 0 = U)

Behaviour:
- Reset: mstatus=0, mie=0, mip=0, mscratch=0, mcause=0, mtval=0, mcycle=0, minstret=0, mtvec=mepc=RESET_PC_VEC, mode=3, redirect_valid=0, redirect_pc=0. Reset mid-trap discards the pending redirect.
- Readable CSRs: mstatus, mie, mip, mtvec, mepc, mcause, mtval, mscratch, mcycle, minstret. Unknown addresses read 0 and ignore writes.
- mip[3]/[7]/[11] are registered copies of irq_msi/mti/mei each cycle; CSR writes to these bits are ignored.
- mip[16+i] is set on a 0->1 edge of irq_plat[i] (1-cycle edge register). It is cleared only by a CSR write of 0 to that bit. Set wins when set and clear occur in the same cycle.
- Interrupt taken when cm_valid && !stall && mstatus.MIE && |(mip & mie). Priority: MEI(11) > MSI(3) > MTI(7) > plat lowest index first.
- Commit priority when !stall && cm_valid: exception > interrupt > mret > CSR op. Only one action per cycle. A lower-priority CSR write is dropped.
- Trap entry (exception or interrupt):
  - mepc = cm_pc; mtval = 0.
  - mcause = {is_irq, code}.
  - mstatus.MPIE = MIE, MIE = 0, MPP = mode; mode = 3.
  - Target: direct = {mtvec[63:2], 2'b0}. If vectored (VECTORED_EN && mtvec[1:0]==1) and interrupt: base + 4*code.
- mret: MIE = MPIE, MPIE = 1, mode = old MPP, MPP = 0; target = mepc.
- CSR op: new value = W: src; S: old | src; C: old & ~src. Target = cm_pc + 4.
- Writing mcycle overrides that cycle's increment.
- Every action asserts redirect_valid for exactly 1 cycle; redirect_pc is set on the next clk edge.
- Counters: mcycle increments every cycle, 64-bit wrap to 0. minstret increments on cm_valid && !stall && !cm_exc && no interrupt taken.
- stall=1 suppresses all commit actions and minstret. mcycle, mip sampling and edge latching continue.

Test Plan:
- Reset, then read mtvec, mepc, mode -> 0x8000_0000, 0x8000_0000, 3; redirect_valid=0.
- CSRW mtvec=0x1001, MIE=1, mie[11]=1; raise irq_mei at pc 0x8000_0100 -> next cycle redirect_pc=0x102C, mcause=0x8000_0000_0000_000B, mepc=0x8000_0100, MIE=0, MPIE=1.
- Pulse irq_plat[2] one cycle with MIE=0 -> mip[18] stays 1. CSRC mip with src=1<<18 -> mip[18]=0. Repeat with a new edge in the same cycle as the clear -> mip[18]=1.
- cm_exc=1 code 8 together with cm_csr_op=CSRW mscratch=5 at pc 0x200 -> mcause=8, mscratch unchanged, redirect_pc=mtvec base.
- mret after trap with MPP=0 -> mode=0, MIE=1, redirect_pc=mepc. Same stimulus with stall=1 -> no redirect, state unchanged.
- Write mcycle=0xFFFF_FFFF_FFFF_FFFF -> reads 0 the following cycle. Commit 3 valid non-trapping instructions -> minstret=3.
